// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into one APB SETUP/ACCESS transfer at a time
// and returns read data / error on a valid/ready response stream. Define APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state;

    logic pready_hit;
    logic pslverr_hit;

    // The slave may float PREADY/PSLVERR; only a driven 1 counts.
    assign pready_hit  = (PREADY === 1'b1);
    assign pslverr_hit = (PSLVERR === 1'b1);
    assign cmd_ready   = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timeout_q;
    logic                 limit_hit;

    // The current wait cycle is the one that brings the count up to the limit.
    assign limit_hit   = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_write ? cmd_wdata : '0;
                        PSTRB   <= cmd_write ? cmd_strb : '0;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready_hit) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= pslverr_hit;
`ifdef APB_MASTER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (limit_hit) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSELx     <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge; expectations come from the bridge's
// transfer rules (latency 3 + wait states, write data/strobes zeroed on reads, timeout abort when enabled).
module tb_apb_master_bridge;

    localparam int TIMEOUT = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int MAX_WAITS = TIMEOUT - 1;
`else
    localparam int MAX_WAITS = 5;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int cycle_cnt = 0;

    apb_master_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSELx(PSELx),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PSTRB(PSTRB),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present a command, act as the APB slave with the given wait states, then hold off the response.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                                 input logic slverr, input int rsp_delay, input bit hold_busy);
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        int          start_cycle;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        exp_rdata = wr ? 32'h0 : rdata;

        @(negedge PCLK);
        checkOutput("idle_cmd_ready", cmd_ready, 1);
        checkOutput("idle_psel", PSELx, 0);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_wdata   = wdata;
        cmd_strb    = strb;
        start_cycle = cycle_cnt;

        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        checkOutput("setup_psel", PSELx, 1);
        checkOutput("setup_penable", PENABLE, 0);
        checkOutput("setup_cmd_ready", cmd_ready, 0);
        checkOutput("setup_paddr", PADDR, addr);
        checkOutput("setup_pwrite", PWRITE, wr);
        checkOutput("setup_pwdata", PWDATA, exp_wdata);
        checkOutput("setup_pstrb", PSTRB, exp_strb);
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);

        for (int i = 0; i <= waits; i++) begin
            @(negedge PCLK);
            checkOutput("access_psel", PSELx, 1);
            checkOutput("access_penable", PENABLE, 1);
            checkOutput("access_paddr", PADDR, addr);
            checkOutput("access_pwrite", PWRITE, wr);
            checkOutput("access_pwdata", PWDATA, exp_wdata);
            checkOutput("access_pstrb", PSTRB, exp_strb);
            checkOutput("access_rsp_valid", rsp_valid, 0);
            if (i == waits) begin
                PREADY  = 1'b1;
                PRDATA  = rdata;
                PSLVERR = slverr;
            end else begin
                PREADY  = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'bz;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end

        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
        checkOutput("rsp_latency", 64'(cycle_cnt - start_cycle), 64'(3 + waits));
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_err", rsp_err, slverr);
        checkOutput("rsp_timeout", rsp_timeout, 0);
        checkOutput("rsp_psel", PSELx, 0);
        checkOutput("rsp_penable", PENABLE, 0);
        if (hold_busy) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
        end

        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge PCLK);
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("hold_rsp_err", rsp_err, slverr);
            checkOutput("hold_cmd_ready", cmd_ready, 0);
            checkOutput("hold_psel", PSELx, 0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;

        @(negedge PCLK);
        rsp_ready = 1'b0;
        checkOutput("done_rsp_valid", rsp_valid, 0);
        checkOutput("done_cmd_ready", cmd_ready, 1);
        checkOutput("done_psel", PSELx, 0);
    endtask

    // Start a read and leave the slave stalled with PREADY floating.
    task automatic startStalledRead(input logic [31:0] addr);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'bz;
        PRDATA    = 32'hDEAD_BEEF;
        checkOutput("stall_setup_psel", PSELx, 1);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_data;
        int          r_waits;

        #12;
        checkOutput("reset_psel", PSELx, 0);
        checkOutput("reset_penable", PENABLE, 0);
        checkOutput("reset_pwrite", PWRITE, 0);
        checkOutput("reset_paddr", PADDR, 0);
        checkOutput("reset_pwdata", PWDATA, 0);
        checkOutput("reset_pstrb", PSTRB, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rsp_timeout", rsp_timeout, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 32'h04, 32'hA5A5_0001, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 32'h08, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0, 1, 1'b0);
        applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b1, 0, 1'b0);
        applyStimulus(1'b1, 32'h10, 32'hCAFE_F00D, 4'h5, 1, 32'h0, 1'b1, 5, 1'b1);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 30; n++) begin
            r_addr  = $urandom & 32'h0000_FFFC;
            r_data  = $urandom;
            r_waits = $urandom_range(0, MAX_WAITS);
            applyStimulus(1'($urandom), r_addr, $urandom, 4'($urandom), r_waits, r_data,
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] reset during ACCESS");
        startStalledRead(32'h20);
        @(negedge PCLK);
        checkOutput("pre_reset_penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_psel", PSELx, 0);
        checkOutput("async_reset_penable", PENABLE, 0);
        checkOutput("async_reset_rsp_valid", rsp_valid, 0);
        PREADY = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            checkOutput("post_reset_cmd_ready", cmd_ready, 1);
            checkOutput("post_reset_rsp_valid", rsp_valid, 0);
            checkOutput("post_reset_psel", PSELx, 0);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        $display("[TB] timeout abort");
        startStalledRead(32'h24);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge PCLK);
            checkOutput("to_access_psel", PSELx, 1);
            checkOutput("to_access_penable", PENABLE, 1);
            checkOutput("to_access_rsp_valid", rsp_valid, 0);
        end
        @(negedge PCLK);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_timeout", rsp_timeout, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_psel", PSELx, 0);
        checkOutput("to_penable", PENABLE, 0);
        PREADY    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        checkOutput("to_done_cmd_ready", cmd_ready, 1);
        applyStimulus(1'b0, 32'h28, 32'h0, 4'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);
`else
        $display("[TB] stall without timeout");
        startStalledRead(32'h24);
        repeat (1000) @(negedge PCLK);
        checkOutput("stall_psel", PSELx, 1);
        checkOutput("stall_penable", PENABLE, 1);
        checkOutput("stall_rsp_valid", rsp_valid, 0);
        checkOutput("stall_rsp_timeout", rsp_timeout, 0);
        PRESETn = 1'b0;
        PREADY  = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        applyStimulus(1'b1, 32'h2C, 32'h0102_0304, 4'hC, 0, 32'h0, 1'b0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so a wedged run still ends with a report.
    initial begin
        #500000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
